// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared pipeline hazard-control types and constants.
package hazard_ctrl_pkg;
  localparam int CNT_W = 16;
  typedef enum logic [2:0] {RUN, FLUSH, MEMWAIT, HALT, STEP} state_t;
  typedef struct packed {
    logic fe;
    logic dc;
    logic ex;
    logic me;
    logic wb;
  } stall_t;
  localparam stall_t ST_NONE = 5'b00000;
  localparam stall_t ST_MEM  = 5'b11110;
  localparam stall_t ST_LU   = 5'b11000;
  localparam stall_t ST_ALL  = 5'b11111;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return &v ? v : v + CNT_W'(1);
  endfunction
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use comparator between execute and decode.
module hazard_detect (
  input  logic       ex_v,
  input  logic       ex_is_load,
  input  logic [4:0] ex_rd,
  input  logic       dc_v,
  input  logic [4:0] dc_rs1,
  input  logic [4:0] dc_rs2,
  output logic       load_use
);
  assign load_use = ex_v & ex_is_load & dc_v & (ex_rd != 5'd0) &
                    ((ex_rd == dc_rs1) | (ex_rd == dc_rs2));
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush/debug-halt controller.
// Outputs decode the registered state plus current inputs; all are forced low in reset.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dc_v,
  input  logic [4:0]       dc_rs1,
  input  logic [4:0]       dc_rs2,
  input  logic             ex_v,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic             ex_taken,
  input  logic             mem_req,
  input  logic             mem_ack,
  input  logic             dbg_halt,
  input  logic             dbg_step,
  output logic             s_fe,
  output logic             s_dc,
  output logic             s_ex,
  output logic             s_me,
  output logic             s_wb,
  output logic             flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);
  state_t state, nxt;
  stall_t st;
  logic fl, hl, load_use, mw, from_step, nxt_step;
  hazard_detect u_detect (
    .ex_v(ex_v),
    .ex_is_load(ex_is_load),
    .ex_rd(ex_rd),
    .dc_v(dc_v),
    .dc_rs1(dc_rs1),
    .dc_rs2(dc_rs2),
    .load_use(load_use)
  );
  assign mw = mem_req & ~mem_ack;
  // from_step remembers that a memory wait began during a single step, so the ack returns to HALT
  always_comb begin
    nxt = state;
    nxt_step = from_step;
    st = ST_NONE;
    fl = 1'b0;
    hl = 1'b0;
    case (state)
      RUN:
        if (mw) begin
          st = ST_MEM;
          nxt = MEMWAIT;
          nxt_step = 1'b0;
        end else if (ex_taken) begin
          fl = 1'b1;
          nxt = FLUSH;
        end else if (load_use) st = ST_LU;
        else if (dbg_halt) nxt = HALT;
      FLUSH: begin
        fl = 1'b1;
        nxt = RUN;
      end
      MEMWAIT:
        if (mem_ack) nxt = (from_step && dbg_halt) ? HALT : RUN;
        else st = ST_MEM;
      HALT: begin
        st = ST_ALL;
        hl = 1'b1;
        nxt = !dbg_halt ? RUN : dbg_step ? STEP : HALT;
      end
      STEP:
        if (mw) begin
          st = ST_MEM;
          nxt = MEMWAIT;
          nxt_step = 1'b1;
        end else nxt = dbg_halt ? HALT : RUN;
      default: nxt = RUN;
    endcase
  end
  assign {s_fe, s_dc, s_ex, s_me, s_wb} = rst_n ? st : ST_NONE;
  assign flush = rst_n & fl;
  assign halted = rst_n & hl;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      from_step <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state <= nxt;
      from_step <= nxt_step;
      if (st.fe) stall_cnt <= sat_inc(stall_cnt);
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors feed an expectation queue; a negedge monitor pops and compares.
module tb_hazard_ctrl;
  logic clk = 1'b0, rst_n;
  logic dc_v, ex_v, ex_is_load, ex_taken, mem_req, mem_ack, dbg_halt, dbg_step;
  logic [4:0] dc_rs1, dc_rs2, ex_rd;
  logic s_fe, s_dc, s_ex, s_me, s_wb, flush, halted;
  logic [15:0] stall_cnt;
  typedef struct {
    logic [4:0]  st;
    logic        fl;
    logic        hl;
    logic [15:0] cnt;
    string       nm;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, errors = 0;
  logic [15:0] exp_cnt = '0;
  hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .dc_v(dc_v), .dc_rs1(dc_rs1), .dc_rs2(dc_rs2),
    .ex_v(ex_v), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_taken(ex_taken),
    .mem_req(mem_req), .mem_ack(mem_ack), .dbg_halt(dbg_halt), .dbg_step(dbg_step),
    .s_fe(s_fe), .s_dc(s_dc), .s_ex(s_ex), .s_me(s_me), .s_wb(s_wb),
    .flush(flush), .halted(halted), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (q.size() != 0) begin
      e = q.pop_front();
      checks++;
      if ({s_fe, s_dc, s_ex, s_me, s_wb, flush, halted, stall_cnt} !== {e.st, e.fl, e.hl, e.cnt}) begin
        errors++;
        $display("FAIL %s: got stalls=%b flush=%b halted=%b cnt=%h, want stalls=%b flush=%b halted=%b cnt=%h",
                 e.nm, {s_fe, s_dc, s_ex, s_me, s_wb}, flush, halted, stall_cnt, e.st, e.fl, e.hl, e.cnt);
      end
    end
  end
  task automatic idle();
    {dc_v, ex_v, ex_is_load, ex_taken, mem_req, mem_ack, dbg_halt, dbg_step} = '0;
    {dc_rs1, dc_rs2, ex_rd} = '0;
  endtask
  task automatic cyc(input logic [4:0] st, input logic fl, input logic hl, input string nm);
    exp_t x;
    if (!rst_n) exp_cnt = '0;
    x.st = st;
    x.fl = fl;
    x.hl = hl;
    x.cnt = exp_cnt;
    x.nm = nm;
    q.push_back(x);
    if (rst_n && st[4]) exp_cnt = (exp_cnt == 16'hFFFF) ? exp_cnt : exp_cnt + 16'd1;
    @(posedge clk);
    #1;
  endtask
  task automatic load_use(input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
    idle();
    {dc_v, ex_v, ex_is_load} = 3'b111;
    ex_rd = rd;
    dc_rs1 = r1;
    dc_rs2 = r2;
  endtask
  initial begin
    rst_n = 1'b0;
    idle();
    mem_req = 1'b1;
    @(posedge clk);
    #1;
    cyc(5'b00000, 0, 0, "reset_outputs");
    rst_n = 1'b1;
    idle();
    cyc(5'b00000, 0, 0, "idle");
    load_use(5'd5, 5'd3, 5'd5);
    cyc(5'b11000, 0, 0, "load_use_rs2");
    idle();
    cyc(5'b00000, 0, 0, "load_use_one_cycle");
    load_use(5'd7, 5'd7, 5'd2);
    cyc(5'b11000, 0, 0, "load_use_rs1");
    load_use(5'd7, 5'd7, 5'd2);
    ex_is_load = 1'b0;
    cyc(5'b00000, 0, 0, "non_load");
    load_use(5'd0, 5'd0, 5'd0);
    cyc(5'b00000, 0, 0, "x0_no_stall");
    load_use(5'd9, 5'd9, 5'd1);
    ex_taken = 1'b1;
    cyc(5'b00000, 1, 0, "branch_lu_flush1");
    idle();
    cyc(5'b00000, 1, 0, "branch_flush2");
    cyc(5'b00000, 0, 0, "branch_done");
    mem_req = 1'b1;
    cyc(5'b11110, 0, 0, "memwait_1");
    ex_taken = 1'b1;
    cyc(5'b11110, 0, 0, "memwait_2_ignore_br");
    ex_taken = 1'b0;
    cyc(5'b11110, 0, 0, "memwait_3");
    mem_ack = 1'b1;
    cyc(5'b00000, 0, 0, "memwait_ack");
    idle();
    cyc(5'b00000, 0, 0, "memwait_run");
    dbg_step = 1'b1;
    cyc(5'b00000, 0, 0, "step_ignored_run");
    idle();
    dbg_halt = 1'b1;
    cyc(5'b00000, 0, 0, "halt_detect");
    ex_taken = 1'b1;
    cyc(5'b11111, 0, 1, "halt_ignore_br");
    ex_taken = 1'b0;
    dbg_step = 1'b1;
    cyc(5'b11111, 0, 1, "halt_step_req");
    dbg_step = 1'b0;
    cyc(5'b00000, 0, 0, "step_cycle");
    cyc(5'b11111, 0, 1, "back_to_halt");
    dbg_step = 1'b1;
    cyc(5'b11111, 0, 1, "halt_step_req2");
    dbg_step = 1'b0;
    mem_req = 1'b1;
    cyc(5'b11110, 0, 0, "step_memwait");
    cyc(5'b11110, 0, 0, "step_memwait_hold");
    mem_ack = 1'b1;
    cyc(5'b00000, 0, 0, "step_mem_ack");
    {mem_req, mem_ack} = 2'b00;
    cyc(5'b11111, 0, 1, "step_mem_to_halt");
    dbg_halt = 1'b0;
    cyc(5'b11111, 0, 1, "halt_release");
    cyc(5'b00000, 0, 0, "halt_to_run");
    mem_req = 1'b1;
    cyc(5'b11110, 0, 0, "rst_mw_1");
    cyc(5'b11110, 0, 0, "rst_mw_2");
    rst_n = 1'b0;
    cyc(5'b00000, 0, 0, "rst_in_memwait");
    rst_n = 1'b1;
    idle();
    cyc(5'b00000, 0, 0, "after_rst_mw");
    ex_taken = 1'b1;
    cyc(5'b00000, 1, 0, "rst_fl_1");
    idle();
    rst_n = 1'b0;
    cyc(5'b00000, 0, 0, "rst_in_flush");
    rst_n = 1'b1;
    cyc(5'b00000, 0, 0, "no_residual_flush");
    mem_req = 1'b1;
    for (int i = 0; i < 70000; i++) cyc(5'b11110, 0, 0, "sat_stall");
    mem_ack = 1'b1;
    cyc(5'b00000, 0, 0, "sat_end");
    idle();
    cyc(5'b00000, 0, 0, "sat_hold");
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
